// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads combinational imem, loads IF/ID,
// and drains the pipeline after the all-ones terminator before raising halted.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ADDR_W       = 8,
  parameter int          DRAIN_CYCLES = 5
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc_plus4,
  output logic              ifid_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES);
  localparam logic [31:0] TERMINATOR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_pc, w_pc_nxt;
  logic [31:0]        r_instr, w_instr_nxt;
  logic [31:0]        r_pc4, w_pc4_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_halted, w_halted_nxt;
  logic [31:0]        r_fcnt, w_fcnt_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_redirect_tgt;
  logic               w_is_term;
  logic               w_unused_rpc_lsbs;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_redirect_tgt    = {redirect_pc[31:2], 2'b00};
  assign w_is_term         = (imem_data == TERMINATOR);
  assign w_unused_rpc_lsbs = ^redirect_pc[1:0];

  assign imem_addr     = r_pc[ADDR_W+1:2];
  assign pc            = r_pc;
  assign ifid_instr    = r_instr;
  assign ifid_pc_plus4 = r_pc4;
  assign ifid_valid    = r_valid;
  assign halted        = r_halted;
  assign fetch_count   = r_fcnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_pc     <= RESET_PC;
      r_instr  <= 32'd0;
      r_pc4    <= 32'd0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_fcnt   <= 32'd0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_pc4    <= w_pc4_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Priority below reset: redirect > stall > normal; DONE ignores everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_pc4_nxt    = r_pc4;
    w_valid_nxt  = r_valid;
    w_halted_nxt = r_halted;
    w_fcnt_nxt   = r_fcnt;
    w_cnt_nxt    = r_cnt;

    unique case (r_state)
      S_RUN, S_DRAIN: begin
        if (redirect_valid) begin
          // A terminator seen on a mispredicted path is cancelled here.
          w_state_nxt = S_RUN;
          w_pc_nxt    = w_redirect_tgt;
          w_instr_nxt = 32'd0;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else if (!stall) begin
          if (r_state == S_DRAIN) begin
            w_instr_nxt = 32'd0;
            w_valid_nxt = 1'b0;
            if (r_cnt == '0) begin
              w_state_nxt  = S_DONE;
              w_halted_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end else if (w_is_term) begin
            w_state_nxt = S_DRAIN;
            w_instr_nxt = 32'd0;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
          end else begin
            w_pc_nxt    = w_pc_plus4;
            w_instr_nxt = imem_data;
            w_pc4_nxt   = w_pc_plus4;
            w_valid_nxt = 1'b1;
            w_fcnt_nxt  = r_fcnt + 32'd1;
          end
        end
      end
      S_DONE: begin
        w_halted_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural model pushes expected outputs into a
// queue each cycle; scenario tasks pop and compare after the clock edge.
module tb_fetch_stage;

  localparam int          ADDR_W   = 8;
  localparam int          DRAIN    = 5;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic              CLK = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'd0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       pc, ifid_instr, ifid_pc_plus4, fetch_count;
  logic              ifid_valid, halted;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  assign imem_data = mem[imem_addr];

  fetch_stage #(.RESET_PC(RST_PC), .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN)) dut (
    .CLK(CLK), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
    .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] fc;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb [$];
  exp_t e, o;
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model state: 0=RUN 1=DRAIN 2=DONE
  logic [31:0] m_pc, m_instr, m_pc4, m_fc;
  logic        m_valid, m_halted;
  int          m_state, m_cnt;

  function automatic exp_t cur();
    return '{pc: pc, instr: ifid_instr, pc4: ifid_pc_plus4, fc: fetch_count,
             valid: ifid_valid, halted: halted};
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic rv,
                            input logic [31:0] rpc);
    logic [31:0] w;
    w = mem[m_pc[ADDR_W+1:2]];
    if (rst) begin
      m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_fc = 0;
      m_valid = 0; m_halted = 0; m_state = 0; m_cnt = 0;
    end else if (m_state == 2) begin
      m_halted = 1;
    end else if (rv) begin
      m_pc = {rpc[31:2], 2'b00}; m_instr = 0; m_valid = 0; m_state = 0;
    end else if (st) begin
      m_state = m_state;
    end else if (m_state == 1) begin
      m_instr = 0; m_valid = 0;
      if (m_cnt == 0) begin m_state = 2; m_halted = 1; end
      else m_cnt = m_cnt - 1;
    end else if (w == 32'hFFFF_FFFF) begin
      m_instr = 0; m_valid = 0; m_state = 1; m_cnt = DRAIN - 1;
    end else begin
      m_instr = w; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1; m_fc = m_fc + 1;
    end
    sb.push_back('{pc: m_pc, instr: m_instr, pc4: m_pc4, fc: m_fc,
                   valid: m_valid, halted: m_halted});
  endtask

  task automatic tick(input logic rst, input logic st, input logic rv,
                      input logic [31:0] rpc);
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
    model_step(rst, st, rv, rpc);
    @(posedge CLK);
    #1;
    reset = 0; stall = 0; redirect_valid = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 0);
      e = sb.pop_front(); o = cur(); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_sb: got %h want %h", o, e);
      end
    end
    n_cmp++;
    if ({pc, ifid_instr, ifid_pc_plus4, ifid_valid, halted, fetch_count} !==
        {RST_PC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got pc=%h instr=%h p4=%h v=%b h=%b fc=%0d",
               pc, ifid_instr, ifid_pc_plus4, ifid_valid, halted, fetch_count);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] want_w [0:1];
    want_w[0] = 32'h2008_0005; want_w[1] = 32'h2009_0003;
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 0);
      e = sb.pop_front(); o = cur(); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fetch_sb%0d: got %h want %h", i, o, e);
      end
      n_cmp++;
      if (ifid_instr !== want_w[i] || ifid_pc_plus4 !== 32'(4 * (i + 1)) || ifid_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fetch_word%0d: got instr=%h p4=%h v=%b want instr=%h p4=%h v=1",
                 i, ifid_instr, ifid_pc_plus4, ifid_valid, want_w[i], 4 * (i + 1));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, 0, 0);
      e = sb.pop_front(); o = cur(); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall_sb%0d: got %h want %h", i, o, e);
      end
      n_cmp++;
      if (pc !== 32'h8 || ifid_instr !== 32'h2009_0003 || fetch_count !== 32'd2) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got pc=%h instr=%h fc=%0d want pc=8 instr=20090003 fc=2",
                 i, pc, ifid_instr, fetch_count);
      end
    end
    tick(0, 0, 0, 0);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL stall_resume_sb: got %h want %h", o, e);
    end
    n_cmp++;
    if (ifid_instr !== 32'h0109_5020 || ifid_pc_plus4 !== 32'hC || fetch_count !== 32'd3) begin
      n_fail++;
      $display("FAIL stall_resume: got instr=%h p4=%h fc=%0d want instr=01095020 p4=c fc=3",
               ifid_instr, ifid_pc_plus4, fetch_count);
    end
  endtask

  task automatic test_terminator();
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0);
      e = sb.pop_front(); o = cur(); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL term_sb%0d: got %h want %h", i, o, e);
      end
      n_cmp++;
      if (halted !== (i == 5) || ifid_valid !== 1'b0 || pc !== 32'hC) begin
        n_fail++;
        $display("FAIL term_edge%0d: got halted=%b v=%b pc=%h want halted=%b v=0 pc=c",
                 i, halted, ifid_valid, pc, i == 5);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(0, i[0], 1, 32'h40);
      e = sb.pop_front(); o = cur(); n_cmp++;
      if (o !== e || halted !== 1'b1 || pc !== 32'hC) begin
        n_fail++;
        $display("FAIL done_ignores_redirect%0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_in_done();
    tick(1, 0, 0, 0);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || pc !== RST_PC || halted !== 1'b0 || fetch_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_in_done: got %h want %h", o, e);
    end
  endtask

  task automatic test_redirect_stall();
    tick(0, 0, 1, 32'h10);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL redir_setup: got %h want %h", o, e);
    end
    tick(0, 1, 1, 32'h42);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || pc !== 32'h40 || ifid_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_over_stall: got pc=%h v=%b want pc=40 v=0", pc, ifid_valid);
    end
    tick(0, 0, 0, 0);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || ifid_pc_plus4 !== 32'h44 || ifid_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_next: got p4=%h v=%b want p4=44 v=1", ifid_pc_plus4, ifid_valid);
    end
  endtask

  task automatic test_drain_redirect();
    // Redirect coinciding with a terminator fetch: no DRAIN entry.
    logic [2:0] st_t [0:6];
    logic [2:0] rv_t [0:6];
    logic [31:0] pc_t [0:6];
    tick(0, 0, 1, 32'hC);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL dr_setup: got %h want %h", o, e); end
    tick(0, 0, 1, 32'h20);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || pc !== 32'h20) begin
      n_fail++;
      $display("FAIL redir_on_term: got pc=%h want pc=20", pc);
    end
    // Back to terminator, drain 2 cycles (one stalled), redirect to 0x20.
    st_t = '{0, 0, 0, 1, 0, 0, 0};
    rv_t = '{1, 0, 0, 0, 0, 1, 0};
    pc_t = '{32'hC, 0, 0, 0, 0, 32'h20, 0};
    for (int i = 0; i < 7; i++) begin
      tick(0, st_t[i][0], rv_t[i][0], pc_t[i]);
      e = sb.pop_front(); o = cur(); n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL drain_redir_sb%0d: got %h want %h", i, o, e);
      end
    end
    n_cmp++;
    if (halted !== 1'b0 || ifid_instr !== mem[8] || ifid_pc_plus4 !== 32'h24 || pc !== 32'h24) begin
      n_fail++;
      $display("FAIL drain_redir_resume: got h=%b instr=%h p4=%h pc=%h want h=0 instr=%h p4=24 pc=24",
               halted, ifid_instr, ifid_pc_plus4, pc, mem[8]);
    end
  endtask

  task automatic test_reset_in_drain();
    tick(0, 0, 1, 32'hC);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      e = sb.pop_front(); o = cur(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL rd_sb%0d: got %h want %h", i, o, e); end
    end
    tick(1, 0, 0, 0);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || pc !== RST_PC || ifid_valid !== 1'b0 || fetch_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_in_drain: got %h want %h", o, e);
    end
    tick(0, 0, 0, 0);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || ifid_instr !== 32'h2008_0005 || fetch_count !== 32'd1) begin
      n_fail++;
      $display("FAIL restart_word0: got instr=%h fc=%0d want instr=20080005 fc=1",
               ifid_instr, fetch_count);
    end
  endtask

  task automatic test_alias_wrap();
    tick(0, 0, 1, 32'h0000_0406);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || pc !== 32'h404 || imem_addr !== 8'd1) begin
      n_fail++;
      $display("FAIL alias_addr: got pc=%h addr=%h want pc=404 addr=01", pc, imem_addr);
    end
    tick(0, 0, 0, 0);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || ifid_instr !== 32'h2009_0003) begin
      n_fail++;
      $display("FAIL alias_fetch: got instr=%h want 20090003", ifid_instr);
    end
    tick(0, 0, 1, 32'hFFFF_FFFC);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || imem_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_addr: got addr=%h want ff", imem_addr);
    end
    tick(0, 0, 0, 0);
    e = sb.pop_front(); o = cur(); n_cmp++;
    if (o !== e || pc !== 32'd0 || ifid_pc_plus4 !== 32'd0 || ifid_instr !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wrap_fetch: got pc=%h p4=%h instr=%h want pc=0 p4=0 instr=12345678",
               pc, ifid_pc_plus4, ifid_instr);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0000_0000;
    mem[0]   = 32'h2008_0005;
    mem[1]   = 32'h2009_0003;
    mem[2]   = 32'h0109_5020;
    mem[3]   = 32'hFFFF_FFFF;
    mem[4]   = 32'h2010_0001;
    mem[8]   = 32'hAC0A_0000;
    mem[9]   = 32'h8C0B_0000;
    mem[255] = 32'h1234_5678;
    @(negedge CLK);
    test_reset();
    test_fetch();
    test_stall();
    test_terminator();
    test_reset_in_done();
    test_redirect_stall();
    test_drain_redirect();
    test_reset_in_drain();
    test_alias_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
